fetch_pc_unit: RTL and testbench

- Parametrised next-generation fetch program counter: generates the instruction-memory fetch address each cycle.
- Handles reset, pipeline flush, stall, unconditional jump, predicted branch and sequential step.
- Adds call/return support via an internal circular return-address stack (RAS).
- Sits at the front of the fetch stage. Drives instruction memory and reports predicted-taken branches to the branch resolution logic.

---
 rtl/fetch_pc_unit.sv | 160 ++++++++++++++++
 tb/tb_fetch_pc_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// fetch_pc_unit
//
// Front-of-fetch program counter. Each rising edge chooses the next fetch
// address from (highest priority first): reset, flush redirect, stall hold,
// call (push return address), return (pop return address), jump,
// predicted-taken branch, sequential step. Calls and returns are served by a
// small circular return-address stack (RAS).
//
// Ports:
//   clk                   clock, all state updates on the rising edge
//   reset                 synchronous active-high reset
//   stall                 hold all state this cycle (flush still applies)
//   flush, flush_address  redirect from execute
//   is_jump/is_call/is_ret/is_branch  decoded control-flow flags
//   target_address        jump/call target, fallback target for ret on empty RAS
//   predict_taken, predict_address    branch predictor result
//   pc                    current fetch address (registered)
//   branch_taken          last update followed a predicted-taken branch
//   branch_taken_address  target of the most recent predicted-taken branch
//   ras_count             number of valid RAS entries (saturates at RAS_DEPTH)
//   ras_overflow          one-cycle pulse: push overwrote the oldest entry
//   ras_underflow         one-cycle pulse: ret seen with an empty RAS
// ---------------------------------------------------------------------------
module fetch_pc_unit #(
  parameter int ADDR_WIDTH = 16,
  parameter int PC_STEP    = 2,
  parameter int RAS_DEPTH  = 4,
  parameter int RESET_PC   = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         stall,
  input  logic                         flush,
  input  logic [ADDR_WIDTH-1:0]        flush_address,
  input  logic                         is_jump,
  input  logic                         is_call,
  input  logic                         is_ret,
  input  logic                         is_branch,
  input  logic [ADDR_WIDTH-1:0]        target_address,
  input  logic                         predict_taken,
  input  logic [ADDR_WIDTH-1:0]        predict_address,
  output logic [ADDR_WIDTH-1:0]        pc,
  output logic                         branch_taken,
  output logic [ADDR_WIDTH-1:0]        branch_taken_address,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_overflow,
  output logic                         ras_underflow
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(PC_STEP);
  localparam logic [ADDR_WIDTH-1:0] RESET_VAL = ADDR_WIDTH'(RESET_PC);
  localparam logic [CNT_W-1:0]      FULL_CNT = CNT_W'(RAS_DEPTH);

  // Architectural state
  logic [ADDR_WIDTH-1:0] pc_reg,  pc_next;
  logic                  bt_reg,  bt_next;
  logic [ADDR_WIDTH-1:0] bta_reg, bta_next;
  logic [PTR_W-1:0]      ptr_reg, ptr_next;
  logic [CNT_W-1:0]      cnt_reg, cnt_next;
  logic                  ovf_reg, ovf_next;
  logic                  unf_reg, unf_next;

  // RAS storage; contents are never reset, only pointer and count are.
  logic [ADDR_WIDTH-1:0] ras_mem [RAS_DEPTH];

  logic                  push_en;
  logic [ADDR_WIDTH-1:0] seq_pc;
  logic [PTR_W-1:0]      ptr_dec;
  logic                  ras_empty;
  logic                  ras_full;

  // Sequential address wraps modulo 2^ADDR_WIDTH by truncation.
  assign seq_pc    = pc_reg + STEP;
  // Pointer is a power-of-two width, so decrement wraps naturally.
  assign ptr_dec   = ptr_reg - 1'b1;
  assign ras_empty = (cnt_reg == '0);
  assign ras_full  = (cnt_reg == FULL_CNT);

  always_comb begin
    pc_next  = seq_pc;
    bt_next  = 1'b0;
    bta_next = bta_reg;
    ptr_next = ptr_reg;
    cnt_next = cnt_reg;
    ovf_next = 1'b0;
    unf_next = 1'b0;
    push_en  = 1'b0;

    if (flush) begin
      pc_next = flush_address;
    end else if (stall) begin
      pc_next = pc_reg;
      bt_next = bt_reg;
    end else if (is_call) begin
      push_en  = 1'b1;
      pc_next  = target_address;
      ptr_next = ptr_reg + 1'b1;
      if (ras_full) begin
        // Oldest entry sits at the slot being written; it is lost.
        ovf_next = 1'b1;
      end else begin
        cnt_next = cnt_reg + 1'b1;
      end
    end else if (is_ret) begin
      if (!ras_empty) begin
        pc_next  = ras_mem[ptr_dec];
        ptr_next = ptr_dec;
        cnt_next = cnt_reg - 1'b1;
      end else begin
        pc_next  = target_address;
        unf_next = 1'b1;
      end
    end else if (is_jump) begin
      pc_next = target_address;
    end else if (is_branch && predict_taken) begin
      pc_next  = predict_address;
      bt_next  = 1'b1;
      bta_next = predict_address;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_reg  <= RESET_VAL;
      bt_reg  <= 1'b0;
      bta_reg <= '0;
      ptr_reg <= '0;
      cnt_reg <= '0;
      ovf_reg <= 1'b0;
      unf_reg <= 1'b0;
    end else begin
      pc_reg  <= pc_next;
      bt_reg  <= bt_next;
      bta_reg <= bta_next;
      ptr_reg <= ptr_next;
      cnt_reg <= cnt_next;
      ovf_reg <= ovf_next;
      unf_reg <= unf_next;
    end
  end

  // Return address shares the same wrap as the sequential step.
  always_ff @(posedge clk) begin
    if (push_en && !reset) begin
      ras_mem[ptr_reg] <= seq_pc;
    end
  end

  assign pc                   = pc_reg;
  assign branch_taken         = bt_reg;
  assign branch_taken_address = bta_reg;
  assign ras_count            = cnt_reg;
  assign ras_overflow         = ovf_reg;
  assign ras_underflow        = unf_reg;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_pc_unit
//
// Directed-vector bench for fetch_pc_unit with default parameters
// (16-bit addresses, step 2, 4-entry RAS, reset pc 0). Inputs are driven
// 1 time unit after a rising edge and outputs are checked 1 unit after the
// next rising edge; expected values are hand-computed.
// ---------------------------------------------------------------------------
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        reset, stall, flush;
  logic [15:0] flush_address;
  logic        is_jump, is_call, is_ret, is_branch;
  logic [15:0] target_address;
  logic        predict_taken;
  logic [15:0] predict_address;
  logic [15:0] pc;
  logic        branch_taken;
  logic [15:0] branch_taken_address;
  logic [2:0]  ras_count;
  logic        ras_overflow, ras_underflow;

  int n_vec = 0;
  int n_err = 0;

  fetch_pc_unit #(
    .ADDR_WIDTH(16), .PC_STEP(2), .RAS_DEPTH(4), .RESET_PC(0)
  ) dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .flush_address(flush_address), .is_jump(is_jump), .is_call(is_call),
    .is_ret(is_ret), .is_branch(is_branch), .target_address(target_address),
    .predict_taken(predict_taken), .predict_address(predict_address),
    .pc(pc), .branch_taken(branch_taken),
    .branch_taken_address(branch_taken_address), .ras_count(ras_count),
    .ras_overflow(ras_overflow), .ras_underflow(ras_underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock: apply current inputs, then report the registered outputs.
  task automatic tick();
    @(posedge clk);
    #1;
    $display("t=%0t pc=%04h bt=%0b bta=%04h cnt=%0d ovf=%0b unf=%0b",
             $time, pc, branch_taken, branch_taken_address, ras_count,
             ras_overflow, ras_underflow);
  endtask

  task automatic idle_inputs();
    reset = 0; stall = 0; flush = 0; is_jump = 0; is_call = 0; is_ret = 0;
    is_branch = 0; predict_taken = 0;
  endtask

  // Expected values for the nested-call sequence
  logic [15:0] call_tgt [5] = '{16'h0020, 16'h0030, 16'h0040, 16'h0050, 16'h0060};
  logic [15:0] ret_exp  [4] = '{16'h0052, 16'h0042, 16'h0032, 16'h0022};

  initial begin
    idle_inputs();
    flush_address = 0; target_address = 0; predict_address = 0;

    // Reset dominates stall and flush
    reset = 1; stall = 1; flush = 1; flush_address = 16'h0040;
    tick();
    check("rst_pc", pc, 16'h0000);
    check("rst_cnt", ras_count, 0);
    check("rst_bt", branch_taken, 0);
    check("rst_bta", branch_taken_address, 0);
    check("rst_ovf", ras_overflow, 0);
    check("rst_unf", ras_underflow, 0);

    // Sequential stepping
    idle_inputs();
    tick(); check("seq1", pc, 16'h0002);
    tick(); check("seq2", pc, 16'h0004);
    tick(); check("seq3", pc, 16'h0006);

    // Wrap at top of address space
    flush = 1; flush_address = 16'hFFFE;
    tick(); check("flush_fffe", pc, 16'hFFFE);
    flush = 0;
    tick(); check("wrap", pc, 16'h0000);

    // Single call/return
    flush = 1; flush_address = 16'h0010;
    tick(); check("flush_10", pc, 16'h0010);
    flush = 0; is_call = 1; target_address = 16'h0100;
    tick(); check("call_pc", pc, 16'h0100); check("call_cnt", ras_count, 1);
    is_call = 0; is_ret = 1; target_address = 16'h0777;
    tick(); check("ret_pc", pc, 16'h0012); check("ret_cnt", ras_count, 0);
    check("ret_unf", ras_underflow, 0);

    // Five nested calls into a 4-deep RAS
    is_ret = 0; flush = 1; flush_address = 16'h0010;
    tick();
    flush = 0; is_call = 1;
    for (int i = 0; i < 5; i++) begin
      target_address = call_tgt[i];
      tick();
      check($sformatf("ncall%0d_pc", i), pc, call_tgt[i]);
      check($sformatf("ncall%0d_cnt", i), ras_count, (i < 4) ? i + 1 : 4);
      check($sformatf("ncall%0d_ovf", i), ras_overflow, (i == 4) ? 1 : 0);
    end
    is_call = 0; is_ret = 1; target_address = 16'h0200;
    for (int i = 0; i < 4; i++) begin
      tick();
      check($sformatf("nret%0d_pc", i), pc, ret_exp[i]);
      check($sformatf("nret%0d_cnt", i), ras_count, 3 - i);
      check($sformatf("nret%0d_ovf", i), ras_overflow, 0);
    end
    tick();
    check("unf_pc", pc, 16'h0200);
    check("unf_pulse", ras_underflow, 1);
    check("unf_cnt", ras_count, 0);
    is_ret = 0;
    tick();
    check("unf_clear", ras_underflow, 0);
    check("unf_seq", pc, 16'h0202);

    // Predicted-taken branch
    is_branch = 1; predict_taken = 1; predict_address = 16'h0080;
    tick();
    check("br_pc", pc, 16'h0080);
    check("br_bt", branch_taken, 1);
    check("br_bta", branch_taken_address, 16'h0080);
    is_branch = 0; predict_taken = 0;
    tick();
    check("br_idle_pc", pc, 16'h0082);
    check("br_idle_bt", branch_taken, 0);
    check("br_idle_bta", branch_taken_address, 16'h0080);

    // Not-taken branch steps sequentially
    is_branch = 1; predict_taken = 0; predict_address = 16'h0999;
    tick();
    check("nt_pc", pc, 16'h0084);
    check("nt_bta", branch_taken_address, 16'h0080);

    // Jump beats branch
    is_jump = 1; predict_taken = 1; target_address = 16'h0400;
    tick();
    check("jmp_pc", pc, 16'h0400);
    check("jmp_bt", branch_taken, 0);
    check("jmp_bta", branch_taken_address, 16'h0080);
    is_jump = 0; is_branch = 0; predict_taken = 0;

    // Stall holds everything even with a call pending
    stall = 1; is_call = 1; target_address = 16'h0500;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("stall%0d_pc", i), pc, 16'h0400);
      check($sformatf("stall%0d_cnt", i), ras_count, 0);
      check($sformatf("stall%0d_ovf", i), ras_overflow, 0);
    end
    // Flush overrides stall
    flush = 1; flush_address = 16'h0300;
    tick();
    check("flush_stall_pc", pc, 16'h0300);
    check("flush_stall_cnt", ras_count, 0);

    // Call wins over ret/jump/branch when all asserted
    flush = 0; stall = 0; is_call = 1; is_ret = 1; is_jump = 1;
    is_branch = 1; predict_taken = 1; target_address = 16'h0600;
    predict_address = 16'h0AAA;
    tick();
    check("prio_pc", pc, 16'h0600);
    check("prio_cnt", ras_count, 1);
    check("prio_bt", branch_taken, 0);

    // Reset during stall clears RAS bookkeeping
    idle_inputs(); reset = 1; stall = 1;
    tick();
    check("rst2_pc", pc, 16'h0000);
    check("rst2_cnt", ras_count, 0);
    check("rst2_bta", branch_taken_address, 0);
    idle_inputs(); is_ret = 1; target_address = 16'h0123;
    tick();
    check("rst2_ret_pc", pc, 16'h0123);
    check("rst2_ret_unf", ras_underflow, 1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
